multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle RISC-V datapath. It decodes the instruction register fields and sequences fetch, decode, execute, memory and writeback states. It produces the ALUControl code that the ALU consumes, plus all mux selects and write enables. A memory-ready handshake stalls the FSM during fetch and data-memory accesses.

Parameters:
RESET_STATE, 4'd0 (S_FETCH), state entered on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
op  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory access completes this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=Result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1 register
ALUSrcB  output  2  00=RD2 register, 01=ImmExt, 10=constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
RegWrite  output  1  register file write enable
IllegalOp  output  1  one-cycle pulse in S_DECODE for an unsupported opcode

Behaviour:
- Single clock domain. Reset is synchronous and active-low.
- When rst_n=0 at a rising clk edge, the state is set to S_FETCH.
- While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0.
- Reset asserted mid-access abandons the access. No write strobe is emitted.
- Moore FSM with a registered state. Outputs decode combinationally from the state, plus Zero and MemReady where noted.
- Every select not listed for a state is 0. ALUOp is internal: 00=add, 01=sub, 10=function-decoded.
- S_FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in S_FETCH until MemReady=1, then goes to S_DECODE.
- S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target lands in ALUOut). Next state by op:
  - 0000011/0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BEQ
  - 1101111 -> S_JAL
  - any other opcode -> S_FETCH with IllegalOp=1 (instruction acts as NOP; PC already advanced).
- S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> S_MEMREAD, else -> S_MEMWRITE.
- S_MEMREAD: AdrSrc=1, ResultSrc=00. Waits for MemReady=1, then -> S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1 -> S_FETCH.
- S_MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1, then -> S_FETCH.
- S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> S_ALUWB.
- S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1 -> S_FETCH.
- S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> S_ALUWB.
- ALU decode:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- ImmSrc is decoded from op in every state: I/load=00, store=01, beq=10, jal=11, other=00.
- Undefined state encodings -> S_FETCH on the next edge.
- Cycle counts with MemReady=1: lw 5, sw 4, R/I 4, beq 3, jal 4.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds output RetireCount [31:0], reset to 0.
  - Increments by 1 on the cycle leaving S_MEMWB, S_ALUWB, S_BEQ or S_MEMWRITE (with MemReady=1).
  - Wraps 0xFFFFFFFF -> 0. Illegal opcodes are not counted.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg: state encodings (S_FETCH=0 .. S_JAL=10, 4-bit), ALUControl codes, ALUOp codes, opcode constants, ImmSrc codes.
- Sub-module alu_decoder: combinational ALUOp/funct3/funct7b5/op[5] -> ALUControl. The FSM lives in multicycle_controller.

Test Plan:
- Reset: rst_n=0 for 2 cycles with op=0110011 -> state S_FETCH, all write enables 0. Release -> IRWrite=PCWrite=1 the first cycle MemReady=1.
- Fetch stall: MemReady=0 for 3 cycles -> IRWrite=PCWrite=0 and state held. MemReady=1 -> S_DECODE next edge.
- add/sub: op=0110011, funct3=000, funct7b5=1 -> in S_EXECR ALUControl=001; funct7b5=0 -> 000. RegWrite=1 in S_ALUWB only. Total 4 cycles.
- addi with funct7b5=1: op=0010011, funct3=000 -> ALUControl=000 (no sub). slti funct3=010 -> 101.
- beq: Zero=1 -> PCWrite=1 in S_BEQ with ALUControl=001. Zero=0 -> PCWrite=0. Both return to S_FETCH.
- lw then sw with MemReady low 2 cycles in S_MEMREAD/S_MEMWRITE -> AdrSrc=1 held, MemWrite held high throughout the sw wait. Unknown op 1111111 -> IllegalOp pulse, back to S_FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// FSM states, ALUOp/ALUControl codes, opcodes and ImmSrc codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] r;
        r = IMM_I;
        case (op)
            OP_STORE: r = IMM_S;
            OP_BEQ:   r = IMM_B;
            OP_JAL:   r = IMM_J;
            default:  r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: ALUOp, funct3, funct7b5, op5 -> ALUControl (combinational).
// Ports: ALUOp[1:0], funct3[2:0], funct7b5, op5 in; ALUControl[2:0] out.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl
);

    // Subtraction only for R-type (op5=1); addi with bit30 set stays add.
    logic w_rsub;
    assign w_rsub = op5 & funct7b5;

    always_comb begin
        ALUControl = ALUC_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUC_ADD;
            ALUOP_SUB: ALUControl = ALUC_SUB;
            ALUOP_FN: begin
                case (funct3)
                    3'b000:  ALUControl = w_rsub ? ALUC_SUB : ALUC_ADD;
                    3'b010:  ALUControl = ALUC_SLT;
                    3'b110:  ALUControl = ALUC_OR;
                    3'b111:  ALUControl = ALUC_AND;
                    default: ALUControl = ALUC_ADD;
                endcase
            end
            default: ALUControl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/exec/mem/wb,
// drives mux selects, write enables and ALUControl; stalls on MemReady.
// Ports: clk, rst_n (sync, active-low), op, funct3, funct7b5, Zero,
// MemReady in; PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
// ALUSrcB, ALUControl, ImmSrc, RegWrite, IllegalOp out.
// Optional macro CTRL_PERF_CNT_EN adds RetireCount[31:0].
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
`ifdef CTRL_PERF_CNT_EN
    output logic        IllegalOp,
    output logic [31:0] RetireCount
`else
    output logic        IllegalOp
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        w_alu_op   = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = MemReady;
                w_pcwrite = MemReady;
                w_next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE: w_next = S_EXECR;
                    OP_ITYPE: w_next = S_EXECI;
                    OP_BEQ:   w_next = S_BEQ;
                    OP_JAL:   w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FN;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FN;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                w_alu_op  = ALUOP_SUB;
                w_pcwrite = Zero;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write enables are held off for as long as reset is asserted.
    assign PCWrite   = rst_n & w_pcwrite;
    assign MemWrite  = rst_n & w_memwrite;
    assign IRWrite   = rst_n & w_irwrite;
    assign RegWrite  = rst_n & w_regwrite;
    assign IllegalOp = rst_n & w_illegal;
    assign ImmSrc    = imm_src(op);

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_retire;
    logic        w_retire;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      w_retire = 1'b1;
            S_MEMWRITE: w_retire = MemReady;
            default:    w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire <= 32'd0;
        end else if (w_retire) begin
            r_retire <= r_retire + 32'd1;
        end
    end

    assign RetireCount = r_retire;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level model
// of expected control words, checked every cycle, plus literal pins.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        RegWrite;
    logic        IllegalOp;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] RetireCount;
`endif

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
`ifdef CTRL_PERF_CNT_EN
        .RetireCount(RetireCount),
`endif
        .IllegalOp  (IllegalOp)
    );

    typedef enum {
        P_IF, P_ID, P_MA, P_MR, P_MWB, P_MW,
        P_EXR, P_EXI, P_AWB, P_BEQ, P_JAL
    } ph_t;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       rw;
        logic       ill;
    } ctl_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    logic chk_en = 1'b0;
    ph_t  cur_ph = P_IF;

    logic [6:0] t_op;
    logic [2:0] t_f3;
    logic       t_f7;
    logic       t_z;

    // Function field decode for R/I arithmetic, straight from the ISA table.
    function automatic logic [2:0] fn_alu(input logic [6:0] o,
                                          input logic [2:0] f3,
                                          input logic f7);
        logic [2:0] a;
        a = 3'b000;
        if (f3 == 3'b000 && o == 7'b0110011 && f7) a = 3'b001;
        else if (f3 == 3'b010) a = 3'b101;
        else if (f3 == 3'b110) a = 3'b011;
        else if (f3 == 3'b111) a = 3'b010;
        return a;
    endfunction

    function automatic ctl_t model(input ph_t ph, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7,
                                   input logic z, input logic mr,
                                   input logic rs);
        ctl_t c;
        logic legal;
        c = '0;
        legal = (o == 7'b0000011) || (o == 7'b0100011) ||
                (o == 7'b0110011) || (o == 7'b0010011) ||
                (o == 7'b1100011) || (o == 7'b1101111);
        if (o == 7'b0100011) c.imm = 2'b01;
        else if (o == 7'b1100011) c.imm = 2'b10;
        else if (o == 7'b1101111) c.imm = 2'b11;
        case (ph)
            P_IF: begin
                c.sb = 2'b10; c.res = 2'b10;
                c.irw = mr; c.pcw = mr;
            end
            P_ID: begin
                c.sa = 2'b01; c.sb = 2'b01; c.ill = !legal;
            end
            P_MA: begin
                c.sa = 2'b10; c.sb = 2'b01;
            end
            P_MR: c.adr = 1'b1;
            P_MWB: begin
                c.res = 2'b01; c.rw = 1'b1;
            end
            P_MW: begin
                c.adr = 1'b1; c.mw = 1'b1;
            end
            P_EXR: begin
                c.sa = 2'b10; c.alu = fn_alu(o, f3, f7);
            end
            P_EXI: begin
                c.sa = 2'b10; c.sb = 2'b01; c.alu = fn_alu(o, f3, f7);
            end
            P_AWB: c.rw = 1'b1;
            P_BEQ: begin
                c.sa = 2'b10; c.alu = 3'b001; c.pcw = z;
            end
            P_JAL: begin
                c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
            end
            default: c = '0;
        endcase
        if (!rs) begin
            c.pcw = 1'b0; c.irw = 1'b0; c.mw = 1'b0;
            c.rw = 1'b0; c.ill = 1'b0;
        end
        return c;
    endfunction

    function automatic ctl_t dut_word();
        ctl_t g;
        g = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, ImmSrc, RegWrite, IllegalOp};
        return g;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            ctl_t e;
            ctl_t g;
            e = model(cur_ph, op, funct3, funct7b5, Zero, MemReady, rst_n);
            g = dut_word();
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ctl %s op=%b t=%0t got=%h want=%h",
                         cur_ph.name(), op, $time, g, e);
            end
        end
    end

    task automatic lit(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic cyc(input ph_t ph, input logic mr, input logic rs);
        @(posedge clk);
        #1;
        rst_n    = rs;
        op       = t_op;
        funct3   = t_f3;
        funct7b5 = t_f7;
        Zero     = t_z;
        MemReady = mr;
        cur_ph   = ph;
        cyc_cnt++;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int fw,
                       input int mwt, input int want_cyc,
                       input logic [2:0] want_alu);
        int start;
        t_op = o; t_f3 = f3; t_f7 = f7; t_z = z;
        start = cyc_cnt;
        for (int i = 0; i < fw; i++) begin
            cyc(P_IF, 1'b0, 1'b1);
            settle();
            lit("fetch_stall", int'({IRWrite, PCWrite}), 0);
        end
        cyc(P_IF, 1'b1, 1'b1);
        settle();
        lit("fetch_done", int'({IRWrite, PCWrite}), 3);
        cyc(P_ID, 1'b1, 1'b1);
        case (o)
            7'b0000011: begin
                cyc(P_MA, 1'b1, 1'b1);
                for (int i = 0; i < mwt; i++) begin
                    cyc(P_MR, 1'b0, 1'b1);
                    settle();
                    lit("lw_adr", int'(AdrSrc), 1);
                end
                cyc(P_MR, 1'b1, 1'b1);
                cyc(P_MWB, 1'b1, 1'b1);
            end
            7'b0100011: begin
                cyc(P_MA, 1'b1, 1'b1);
                for (int i = 0; i < mwt; i++) begin
                    cyc(P_MW, 1'b0, 1'b1);
                    settle();
                    lit("sw_hold", int'({AdrSrc, MemWrite}), 3);
                end
                cyc(P_MW, 1'b1, 1'b1);
            end
            7'b0110011: begin
                cyc(P_EXR, 1'b1, 1'b1);
                settle();
                lit("r_alu", int'(ALUControl), int'(want_alu));
                cyc(P_AWB, 1'b1, 1'b1);
            end
            7'b0010011: begin
                cyc(P_EXI, 1'b1, 1'b1);
                settle();
                lit("i_alu", int'(ALUControl), int'(want_alu));
                cyc(P_AWB, 1'b1, 1'b1);
            end
            7'b1100011: begin
                cyc(P_BEQ, 1'b1, 1'b1);
                settle();
                lit("beq_alu", int'(ALUControl), int'(want_alu));
            end
            7'b1101111: begin
                cyc(P_JAL, 1'b1, 1'b1);
                cyc(P_AWB, 1'b1, 1'b1);
            end
            default: begin
                settle();
                lit("illegal", int'(IllegalOp), 1);
            end
        endcase
        lit("cycles", cyc_cnt - start, want_cyc);
    endtask

    initial begin
        rst_n = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; MemReady = 1'b1;
        t_op = 7'b0110011; t_f3 = 3'b000; t_f7 = 1'b0; t_z = 1'b0;

        cyc(P_IF, 1'b1, 1'b0);
        chk_en = 1'b1;
        settle();
        lit("rst_word", int'(dut_word()), 17'b0_0_0_0_10_00_10_000_00_0_0);
        cyc(P_IF, 1'b1, 1'b0);

        //  op          f3     f7 z  fw mw cyc alu
        run(7'b0110011, 3'b000, 1, 0, 3, 0, 7, 3'b001);
        run(7'b0110011, 3'b000, 0, 0, 0, 0, 4, 3'b000);
        run(7'b0110011, 3'b111, 0, 1, 0, 0, 4, 3'b010);
        run(7'b0110011, 3'b110, 0, 0, 0, 0, 4, 3'b011);
        run(7'b0110011, 3'b010, 0, 0, 1, 0, 5, 3'b101);
        run(7'b0010011, 3'b000, 1, 0, 0, 0, 4, 3'b000);
        run(7'b0010011, 3'b010, 0, 0, 0, 0, 4, 3'b101);
        run(7'b0010011, 3'b001, 0, 0, 0, 0, 4, 3'b000);
        run(7'b1100011, 3'b000, 0, 1, 0, 0, 3, 3'b001);
        run(7'b1100011, 3'b000, 0, 0, 0, 0, 3, 3'b001);
        run(7'b0000011, 3'b010, 0, 0, 0, 2, 7, 3'b000);
        run(7'b0100011, 3'b010, 0, 1, 0, 2, 6, 3'b000);
        run(7'b0000011, 3'b010, 0, 0, 0, 0, 5, 3'b000);
        run(7'b0100011, 3'b010, 0, 0, 0, 0, 4, 3'b000);
        run(7'b1101111, 3'b000, 0, 0, 0, 0, 4, 3'b000);
        run(7'b1111111, 3'b000, 0, 0, 0, 0, 2, 3'b000);

        // Store abandoned by reset while waiting on memory.
        t_op = 7'b0100011; t_f3 = 3'b010; t_f7 = 1'b0; t_z = 1'b0;
        cyc(P_IF, 1'b1, 1'b1);
        cyc(P_ID, 1'b1, 1'b1);
        cyc(P_MA, 1'b1, 1'b1);
        cyc(P_MW, 1'b0, 1'b1);
        cyc(P_MW, 1'b0, 1'b0);
        settle();
        lit("rst_mw", int'(MemWrite), 0);
        run(7'b0010011, 3'b111, 0, 0, 0, 0, 4, 3'b010);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
